expmul_row_ctrl: RTL and testbench

- Per-query-row sequencer for the expmul stage of the attention datapath.
- Consumes the score stream (s, v_star) for one query row and maintains the running maximum m.
- Issues one expmul transaction per key, with m, m_prev and o_star_prev.
- Waits for the accumulated o_star from the downstream adder before issuing the next key, because each issue depends on the previous result.
- Emits the final o_star and m at end of row.

---
 rtl/expmul_row_ctrl_pkg.sv | 19 +
 rtl/expmul_row_ctrl_running_max.sv | 59 +++++
 rtl/expmul_row_ctrl.sv | 149 ++++++++++++++
 tb/tb_expmul_row_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expmul_row_ctrl_pkg.sv
// Shared types and constants for the expmul stage (row controller and expmul datapath).
package expmul_row_ctrl_pkg;

  localparam int unsigned INT_W    = 16;
  localparam int unsigned VEC_LEN  = 64;
  localparam int unsigned ELEM_W   = 16;
  localparam int unsigned MAX_KEYS = 512;
  localparam int unsigned VEC_W    = VEC_LEN * ELEM_W;
  localparam int unsigned CNT_W    = $clog2(MAX_KEYS + 1);

  typedef logic signed [INT_W-1:0] INT_T;
  typedef logic [VEC_W-1:0]        STAR_VECTOR_T;

  // Most-negative score; reported as the max of an empty row.
  localparam INT_T INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT_IN, ISSUE, WAIT_O, DONE} ROW_STATE_T;

endpackage

// File: rtl/expmul_row_ctrl_running_max.sv
// Running signed maximum of the score stream. On capture it registers the max before
// and including the new score; the committed max only advances on commit.
module expmul_row_ctrl_running_max
  import expmul_row_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             first_i,
  input  logic             commit_i,
  input  logic             load_min_i,
  input  logic [INT_W-1:0] s_i,
  output logic [INT_W-1:0] m_prev_o,
  output logic [INT_W-1:0] m_next_o,
  output logic [INT_W-1:0] m_cur_o
);

  INT_T m_cur_q, m_cur_d, m_prev_q, m_prev_d, m_next_q, m_next_d, s_val;

  // First key bypasses the stale max; ties keep the current max.
  always_comb begin
    s_val    = $signed(s_i);
    m_prev_d = m_prev_q;
    m_next_d = m_next_q;
    m_cur_d  = m_cur_q;
    if (capture_i) begin
      if (first_i) begin
        m_prev_d = s_val;
        m_next_d = s_val;
      end else begin
        m_prev_d = m_cur_q;
        m_next_d = (s_val > m_cur_q) ? s_val : m_cur_q;
      end
    end
    if (commit_i) begin
      m_cur_d = m_next_q;
    end else if (load_min_i) begin
      m_cur_d = INT_MIN;
    end
  end

  // Max registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_cur_q  <= '0;
      m_prev_q <= '0;
      m_next_q <= '0;
    end else begin
      m_cur_q  <= m_cur_d;
      m_prev_q <= m_prev_d;
      m_next_q <= m_next_d;
    end
  end

  assign m_prev_o = m_prev_q;
  assign m_next_o = m_next_q;
  assign m_cur_o  = m_cur_q;

endmodule

// File: rtl/expmul_row_ctrl.sv
// Per-query-row sequencer: accepts one score/V beat per key, issues one expmul request,
// waits for the accumulated o_star, and reports the row result at the end.
module expmul_row_ctrl
  import expmul_row_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] row_len,
  output logic             busy,
  input  logic             vld_in,
  output logic             rdy_out,
  input  logic [INT_W-1:0] s_in,
  input  logic [VEC_W-1:0] v_star_in,
  output logic             exp_vld,
  input  logic             exp_rdy,
  output logic [INT_W-1:0] exp_m,
  output logic [INT_W-1:0] exp_m_prev,
  output logic [INT_W-1:0] exp_s,
  output logic [VEC_W-1:0] exp_v_star,
  output logic [VEC_W-1:0] exp_o_star_prev,
  input  logic             o_vld_in,
  input  logic [VEC_W-1:0] o_star_in,
  output logic             done_vld,
  input  logic             done_rdy,
  output logic [VEC_W-1:0] o_final,
  output logic [INT_W-1:0] m_final
);

  ROW_STATE_T       state_q, state_d;
  logic [CNT_W-1:0] row_len_q, row_len_d, count_q, count_d, count_inc;
  logic             first_q, first_d;
  logic [INT_W-1:0] s_q, s_d;
  STAR_VECTOR_T     v_q, v_d, o_prev_q, o_prev_d, o_acc_q, o_acc_d;
  logic             capture, commit, load_min;
  logic [INT_W-1:0] m_prev, m_next, m_cur;

  expmul_row_ctrl_running_max u_running_max (
    .clk_i      (clk),
    .rst_i      (rst),
    .capture_i  (capture),
    .first_i    (first_q),
    .commit_i   (commit),
    .load_min_i (load_min),
    .s_i        (s_in),
    .m_prev_o   (m_prev),
    .m_next_o   (m_next),
    .m_cur_o    (m_cur)
  );

  // Next-state and holding-register updates; everything holds unless a handshake fires.
  always_comb begin
    state_d   = state_q;
    row_len_d = row_len_q;
    count_d   = count_q;
    first_d   = first_q;
    s_d       = s_q;
    v_d       = v_q;
    o_prev_d  = o_prev_q;
    o_acc_d   = o_acc_q;
    capture   = 1'b0;
    commit    = 1'b0;
    load_min  = 1'b0;
    count_inc = count_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          row_len_d = row_len;
          count_d   = '0;
          first_d   = 1'b1;
          o_acc_d   = '0;
          if (row_len == '0) begin
            load_min = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = WAIT_IN;
          end
        end
      end
      WAIT_IN: begin
        if (vld_in) begin
          capture  = 1'b1;
          s_d      = s_in;
          v_d      = v_star_in;
          o_prev_d = first_q ? '0 : o_acc_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (exp_rdy) begin
          commit  = 1'b1;
          first_d = 1'b0;
          state_d = WAIT_O;
        end
      end
      WAIT_O: begin
        if (o_vld_in) begin
          o_acc_d = o_star_in;
          count_d = count_inc;
          state_d = (count_inc == row_len_q) ? DONE : WAIT_IN;
        end
      end
      DONE: begin
        if (done_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers with synchronous reset; reset aborts any row in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_len_q <= '0;
      count_q   <= '0;
      first_q   <= 1'b0;
      s_q       <= '0;
      v_q       <= '0;
      o_prev_q  <= '0;
      o_acc_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_len_q <= row_len_d;
      count_q   <= count_d;
      first_q   <= first_d;
      s_q       <= s_d;
      v_q       <= v_d;
      o_prev_q  <= o_prev_d;
      o_acc_q   <= o_acc_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign rdy_out         = (state_q == WAIT_IN);
  assign exp_vld         = (state_q == ISSUE);
  assign done_vld        = (state_q == DONE);
  assign exp_m           = m_next;
  assign exp_m_prev      = m_prev;
  assign exp_s           = s_q;
  assign exp_v_star      = v_q;
  assign exp_o_star_prev = o_prev_q;
  assign o_final         = done_vld ? o_acc_q : '0;
  assign m_final         = done_vld ? m_cur : '0;

  // Rows longer than MAX_KEYS would overflow the key counter.
  row_len_legal_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && start) |-> (row_len <= CNT_W'(MAX_KEYS)));

endmodule

// File: tb/tb_expmul_row_ctrl.sv
// Scoreboard bench for expmul_row_ctrl: stimulus pushes expected transactions, a monitor
// pops and compares them whenever the DUT completes an expmul or row-result handshake.
module tb_expmul_row_ctrl;

  localparam int IW   = 16;
  localparam int VW   = 1024;
  localparam int CW   = 10;
  localparam int MAXR = 8;
  localparam logic [IW-1:0] IMIN = 16'h8000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] row_len = '0;
  logic          busy, rdy_out, exp_vld, done_vld;
  logic          vld_in = 1'b0, exp_rdy = 1'b0, o_vld_in = 1'b0, done_rdy = 1'b0;
  logic [IW-1:0] s_in = '0;
  logic [VW-1:0] v_star_in = '0, o_star_in = '0;
  logic [IW-1:0] exp_m, exp_m_prev, exp_s, m_final;
  logic [VW-1:0] exp_v_star, exp_o_star_prev, o_final;

  expmul_row_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .row_len         (row_len),
    .busy            (busy),
    .vld_in          (vld_in),
    .rdy_out         (rdy_out),
    .s_in            (s_in),
    .v_star_in       (v_star_in),
    .exp_vld         (exp_vld),
    .exp_rdy         (exp_rdy),
    .exp_m           (exp_m),
    .exp_m_prev      (exp_m_prev),
    .exp_s           (exp_s),
    .exp_v_star      (exp_v_star),
    .exp_o_star_prev (exp_o_star_prev),
    .o_vld_in        (o_vld_in),
    .o_star_in       (o_star_in),
    .done_vld        (done_vld),
    .done_rdy        (done_rdy),
    .o_final         (o_final),
    .m_final         (m_final)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] m, mp, s;
    logic [VW-1:0] v, op;
  } exp_t;
  typedef struct {
    logic [IW-1:0] m;
    logic [VW-1:0] o;
  } done_t;

  exp_t          exp_q[$];
  done_t         done_q[$];
  logic [VW-1:0] ret_q[$];
  int            total = 0, bad = 0;
  bit            sb_off = 0, hold_exp = 0, hold_done = 0, spur_en = 0;

  logic signed [IW-1:0] sc [MAXR];
  logic [VW-1:0]        vv [MAXR];
  logic [VW-1:0]        rr [MAXR];

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    int idx;
    idx = 0;
    total++;
    if (got !== want) begin
      for (int i = VW / 16 - 1; i >= 0; i--) if (got[i*16 +: 16] !== want[i*16 +: 16]) idx = i;
      bad++;
      $display("FAIL %s: elem %0d got %h want %h", name, idx, got[idx*16 +: 16],
               want[idx*16 +: 16]);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no/unexpected event, want expected handshake", name);
  endtask

  function automatic logic [VW-1:0] vec_rand();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_fill(input logic [15:0] e);
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 16; i++) v[i*16 +: 16] = e;
    return v;
  endfunction

  // Maximum of the first n scores of the current row.
  function automatic logic signed [IW-1:0] pmax(input int n);
    logic signed [IW-1:0] mx;
    mx = sc[0];
    for (int i = 1; i < n; i++) if (sc[i] > mx) mx = sc[i];
    return mx;
  endfunction

  task automatic push_row(input int len);
    exp_t  e;
    done_t d;
    for (int k = 0; k < len; k++) begin
      e.mp = pmax((k == 0) ? 1 : k);
      e.m  = pmax(k + 1);
      e.s  = sc[k];
      e.v  = vv[k];
      e.op = (k == 0) ? '0 : rr[k-1];
      exp_q.push_back(e);
      ret_q.push_back(rr[k]);
    end
    d.m = (len == 0) ? IMIN : pmax(len);
    d.o = (len == 0) ? '0 : rr[len-1];
    done_q.push_back(d);
  endtask

  task automatic pulse_start(input int len);
    start   = 1'b1;
    row_len = CW'(len);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_beat(input logic [IW-1:0] s, input logic [VW-1:0] v);
    int n;
    n = 0;
    vld_in = 1'b1;
    s_in = s;
    v_star_in = v;
    while (!rdy_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail("beat_timeout");
    @(negedge clk);
    vld_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("idle_timeout");
  endtask

  task automatic wait_high(input int which, input string name);
    int n;
    n = 0;
    while (!((which == 0) ? exp_vld : (which == 1) ? done_vld : rdy_out) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail(name);
  endtask

  task automatic run_row(input int len);
    push_row(len);
    wait_idle();
    pulse_start(len);
    for (int k = 0; k < len; k++) begin
      // start mid-row must be ignored
      if (k > 0 && spur_en && $urandom_range(0, 2) == 0) pulse_start($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(sc[k], vv[k]);
    end
    wait_idle();
  endtask

  // Handshake-ready drivers.
  initial forever begin
    @(negedge clk);
    exp_rdy  = hold_exp ? 1'b0 : ($urandom_range(0, 3) != 0);
    done_rdy = hold_done ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Downstream adder model: returns the row's o_star values in issue order, and injects
  // stray o_vld_in pulses only while no response is owed.
  initial begin : responder
    bit            pend;
    int            dly;
    logic [VW-1:0] val;
    pend = 0;
    dly = 0;
    val = '0;
    forever begin
      @(negedge clk);
      o_vld_in = 1'b0;
      if (pend && dly == 0) begin
        o_vld_in  = 1'b1;
        o_star_in = val;
        pend      = 0;
      end else if (pend) begin
        dly--;
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        o_vld_in  = 1'b1;
        o_star_in = vec_rand();
      end
      #1;
      if (!rst && exp_vld && exp_rdy) begin
        val  = (ret_q.size() != 0) ? ret_q.pop_front() : vec_rand();
        pend = 1;
        dly  = $urandom_range(0, 3);
      end
    end
  end

  // Monitor: compare each completed handshake against the scoreboard.
  initial forever begin
    @(negedge clk);
    #1;
    if (!sb_off && !rst) begin
      if (exp_vld && exp_rdy) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_exp");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("exp_m", VW'(exp_m), VW'(e.m));
          chk("exp_m_prev", VW'(exp_m_prev), VW'(e.mp));
          chk("exp_s", VW'(exp_s), VW'(e.s));
          chk("exp_v_star", exp_v_star, e.v);
          chk("exp_o_star_prev", exp_o_star_prev, e.op);
        end
      end
      if (done_vld && done_rdy) begin
        if (done_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("m_final", VW'(m_final), VW'(d.m));
          chk("o_final", o_final, d.o);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_rdy_out", VW'(rdy_out), VW'(0));
    chk("rst_exp_vld", VW'(exp_vld), VW'(0));
    chk("rst_done_vld", VW'(done_vld), VW'(0));
    chk("rst_m_final", VW'(m_final), VW'(0));
    chk("rst_o_final", o_final, '0);
    @(negedge clk);
    rst = 1'b0;

    // Single key.
    sc[0] = 16'sd5;
    vv[0] = vec_fill(16'd3);
    rr[0] = vec_fill(16'd7);
    run_row(1);

    // Max tracking.
    sc[0] = 16'sd2;
    sc[1] = 16'sd9;
    sc[2] = -16'sd4;
    for (int k = 0; k < 3; k++) begin
      vv[k] = vec_rand();
      rr[k] = vec_rand();
    end
    run_row(3);

    // Zero-length row.
    push_row(0);
    wait_idle();
    hold_done = 1;
    pulse_start(0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("zl_done_vld", VW'(done_vld), VW'(1));
      chk("zl_m_final", VW'(m_final), VW'(IMIN));
      chk("zl_o_final", o_final, '0);
      chk("zl_exp_vld", VW'(exp_vld), VW'(0));
      @(negedge clk);
    end
    hold_done = 0;
    wait_idle();

    // Backpressure on the expmul request and on the row result.
    for (int k = 0; k < 2; k++) begin
      sc[k] = $urandom;
      vv[k] = vec_rand();
      rr[k] = vec_rand();
    end
    push_row(2);
    wait_idle();
    hold_exp  = 1;
    hold_done = 1;
    pulse_start(2);
    send_beat(sc[0], vv[0]);
    wait_high(0, "bp_exp_timeout");
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_exp_vld", VW'(exp_vld), VW'(1));
      chk("bp_rdy_out", VW'(rdy_out), VW'(0));
      chk("bp_exp_m", VW'(exp_m), VW'(sc[0]));
      chk("bp_exp_s", VW'(exp_s), VW'(sc[0]));
      chk("bp_exp_v", exp_v_star, vv[0]);
      chk("bp_exp_op", exp_o_star_prev, '0);
      @(negedge clk);
    end
    hold_exp = 0;
    send_beat(sc[1], vv[1]);
    wait_high(1, "bp_done_timeout");
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_done_vld", VW'(done_vld), VW'(1));
      chk("bp_o_final", o_final, rr[1]);
      chk("bp_m_final", VW'(m_final), VW'(pmax(2)));
      @(negedge clk);
    end
    hold_done = 0;
    wait_idle();

    // Reset while key 2 of 4 sits in ISSUE.
    sb_off = 1;
    for (int k = 0; k < 4; k++) begin
      sc[k] = $urandom;
      vv[k] = vec_rand();
      ret_q.push_back(vec_rand());
    end
    pulse_start(4);
    send_beat(sc[0], vv[0]);
    wait_high(2, "rr_rdy_timeout");
    hold_exp = 1;
    send_beat(sc[1], vv[1]);
    wait_high(0, "rr_exp_timeout");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rr_busy", VW'(busy), VW'(0));
    chk("rr_exp_vld", VW'(exp_vld), VW'(0));
    chk("rr_done_vld", VW'(done_vld), VW'(0));
    rst = 1'b0;
    hold_exp = 0;
    ret_q.delete();
    sb_off = 0;
    @(negedge clk);

    // Random rows with stray start and o_vld_in events.
    spur_en = 1;
    for (int r = 0; r < 8; r++) begin
      int len;
      len = (r == 0) ? 4 : $urandom_range(0, 6);
      for (int k = 0; k < len; k++) begin
        sc[k] = ($urandom_range(0, 2) == 0) ? IW'($signed($urandom_range(0, 4)) - 2) : IW'($urandom);
        vv[k] = vec_rand();
        rr[k] = vec_rand();
      end
      run_row(len);
    end
    spur_en = 0;
    repeat (5) @(negedge clk);
    chk("sb_exp_left", VW'(exp_q.size()), VW'(0));
    chk("sb_done_left", VW'(done_q.size()), VW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
